// File: rtl/riscv_mem_arbiter.sv
// rtl/riscv_mem_arbiter.sv - shares one main-memory block port between I-cache refill and D-cache FSM
//
// Optional feature macro: ARB_ROUND_ROBIN_EN (round-robin between caches on a tie;
// fixed priority dc_wren > dc_rden > ic_rden when undefined).
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   ic_rden/ic_addr          I-cache block read request (level) and address
//   ic_ready/ic_rdata        I-cache completion pulse and read block
//   dc_rden/dc_wren/dc_addr  D-cache allocate / write-back request (level) and address
//   dc_wdata                 D-cache write-back block
//   dc_ready/dc_rdata        D-cache completion pulse and read block
//   mem_rden/mem_wren        registered memory strobes
//   mem_addr/mem_wdata       registered memory address and write block
//   mem_ready/mem_rdata      memory completion pulse and read block
//   busy                     high while a transaction is outstanding
//   timeout_err              sticky watchdog flag, cleared only by rst
module riscv_mem_arbiter #(
    parameter int ADDR_W         = 64,
    parameter int BLOCK_W        = 128,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ic_rden,
    input  logic [ADDR_W-1:0]  ic_addr,
    output logic               ic_ready,
    output logic [BLOCK_W-1:0] ic_rdata,
    input  logic               dc_rden,
    input  logic               dc_wren,
    input  logic [ADDR_W-1:0]  dc_addr,
    input  logic [BLOCK_W-1:0] dc_wdata,
    output logic               dc_ready,
    output logic [BLOCK_W-1:0] dc_rdata,
    output logic               mem_rden,
    output logic               mem_wren,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [BLOCK_W-1:0] mem_wdata,
    input  logic               mem_ready,
    input  logic [BLOCK_W-1:0] mem_rdata,
    output logic               busy,
    output logic               timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_BUSY_I  = 2'd1;
    localparam logic [1:0] S_BUSY_DR = 2'd2;
    localparam logic [1:0] S_BUSY_DW = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] wd_cnt;
    logic             d_req;
    logic             d_wins;

    assign d_req = dc_wren | dc_rden;

`ifdef ARB_ROUND_ROBIN_EN
    // lock: we are in the IDLE cycle right after a write-back completed.
    // last_d: the D-cache owned the most recent completed transaction.
    logic lock;
    logic last_d;

    // D wins a tie when I was served last, or when the write-back->allocate
    // pair must stay together. dc_wren still beats dc_rden inside D.
    assign d_wins = d_req & (~ic_rden | ~last_d | (lock & dc_rden));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock   <= 1'b0;
            last_d <= 1'b1;
        end else if (state == S_IDLE) begin
            lock <= 1'b0;
        end else if (mem_ready) begin
            lock   <= (state == S_BUSY_DW);
            last_d <= (state != S_BUSY_I);
        end
    end
`else
    // Under fixed priority D always beats I, so the write-back->allocate
    // lock holds without any extra state.
    assign d_wins = d_req;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            mem_rden    <= 1'b0;
            mem_wren    <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else if (state == S_IDLE) begin
            if (d_wins) begin
                state     <= dc_wren ? S_BUSY_DW : S_BUSY_DR;
                mem_wren  <= dc_wren;
                mem_rden  <= ~dc_wren;
                mem_addr  <= dc_addr;
                mem_wdata <= dc_wdata;
                wd_cnt    <= '0;
            end else if (ic_rden) begin
                state    <= S_BUSY_I;
                mem_rden <= 1'b1;
                mem_wren <= 1'b0;
                mem_addr <= ic_addr;
                wd_cnt   <= '0;
            end
        end else if (mem_ready) begin
            // Completion beats the watchdog even on the limit cycle.
            state    <= S_IDLE;
            mem_rden <= 1'b0;
            mem_wren <= 1'b0;
        end else if (wd_cnt != CNT_MAX) begin
            wd_cnt <= wd_cnt + CNT_W'(1);
            if (wd_cnt == CNT_MAX - CNT_W'(1)) begin
                timeout_err <= 1'b1;
            end
        end
    end

    assign busy     = (state != S_IDLE);
    assign ic_ready = (state == S_BUSY_I) & mem_ready;
    assign dc_ready = ((state == S_BUSY_DR) | (state == S_BUSY_DW)) & mem_ready;
    assign ic_rdata = mem_rdata;
    assign dc_rdata = mem_rdata;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb/tb_riscv_mem_arbiter.sv - directed self-checking bench for riscv_mem_arbiter
module tb_riscv_mem_arbiter;

    localparam int ADDR_W  = 64;
    localparam int BLOCK_W = 128;

    logic               clk = 1'b0;
    logic               rst;
    logic               ic_rden;
    logic [ADDR_W-1:0]  ic_addr;
    logic               ic_ready;
    logic [BLOCK_W-1:0] ic_rdata;
    logic               dc_rden;
    logic               dc_wren;
    logic [ADDR_W-1:0]  dc_addr;
    logic [BLOCK_W-1:0] dc_wdata;
    logic               dc_ready;
    logic [BLOCK_W-1:0] dc_rdata;
    logic               mem_rden;
    logic               mem_wren;
    logic [ADDR_W-1:0]  mem_addr;
    logic [BLOCK_W-1:0] mem_wdata;
    logic               mem_ready;
    logic [BLOCK_W-1:0] mem_rdata;
    logic               busy;
    logic               timeout_err;

    int checks   = 0;
    int failures = 0;

    logic [BLOCK_W-1:0] pat_a = {32{4'hA}};
    logic [BLOCK_W-1:0] pat_5 = {32{4'h5}};
    logic [BLOCK_W-1:0] pat_c = {16{8'hC3}};
    logic [ADDR_W-1:0]  first_addr;
    logic [ADDR_W-1:0]  second_addr;

    riscv_mem_arbiter #(
        .ADDR_W(ADDR_W),
        .BLOCK_W(BLOCK_W),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst),
        .ic_rden(ic_rden), .ic_addr(ic_addr), .ic_ready(ic_ready), .ic_rdata(ic_rdata),
        .dc_rden(dc_rden), .dc_wren(dc_wren), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_ready(dc_ready), .dc_rdata(dc_rdata),
        .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [BLOCK_W-1:0] obs, input logic [BLOCK_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; ic_rden = 0; ic_addr = '0; dc_rden = 0; dc_wren = 0;
        dc_addr = '0; dc_wdata = '0; mem_ready = 0; mem_rdata = '0;
        step(); step();
        check("rst_busy", busy, 0);
        check("rst_mem_rden", mem_rden, 0);
        check("rst_mem_wren", mem_wren, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_timeout", timeout_err, 0);
        rst = 1'b0;
        step();

        // I-cache read, mem_ready three cycles after mem_rden rises
        ic_rden = 1; ic_addr = 64'h1000;
        step();
        check("t1_mem_rden", mem_rden, 1);
        check("t1_mem_addr", mem_addr, 64'h1000);
        check("t1_busy", busy, 1);
        step();
        check("t1_hold_rden", mem_rden, 1);
        step();
        mem_ready = 1; mem_rdata = pat_a;
        #1;
        check("t1_ic_ready", ic_ready, 1);
        check("t1_ic_rdata", ic_rdata, pat_a);
        check("t1_dc_ready", dc_ready, 0);
        step();
        mem_ready = 0; ic_rden = 0;
        #1;
        check("t1_ic_ready_pulse", ic_ready, 0);
        check("t1_rden_clear", mem_rden, 0);
        check("t1_idle", busy, 0);

        // Write-back then allocate with I-cache waiting throughout
        step();
        dc_wren = 1; dc_addr = 64'h2000; dc_wdata = pat_5; ic_rden = 1; ic_addr = 64'h1000;
        step();
        check("t2_wren", mem_wren, 1);
        check("t2_wr_rden", mem_rden, 0);
        check("t2_wr_addr", mem_addr, 64'h2000);
        check("t2_wdata", mem_wdata, pat_5);
        mem_ready = 1;
        #1;
        check("t2_dw_dc_ready", dc_ready, 1);
        check("t2_dw_ic_ready", ic_ready, 0);
        step();
        mem_ready = 0; dc_wren = 0; dc_rden = 1; dc_addr = 64'h3000;
        #1;
        check("t2_bubble_busy", busy, 0);
        check("t2_bubble_wren", mem_wren, 0);
        step();
        check("t2_dr_rden", mem_rden, 1);
        check("t2_dr_addr", mem_addr, 64'h3000);
        mem_ready = 1; mem_rdata = pat_c;
        #1;
        check("t2_dr_dc_ready", dc_ready, 1);
        check("t2_dr_dc_rdata", dc_rdata, pat_c);
        check("t2_dr_ic_ready", ic_ready, 0);
        step();
        mem_ready = 0; dc_rden = 0;
        step();
        check("t2_i_addr", mem_addr, 64'h1000);
        check("t2_i_rden", mem_rden, 1);
        mem_ready = 1;
        #1;
        check("t2_i_ready", ic_ready, 1);
        step();
        mem_ready = 0; ic_rden = 0;

        // Simultaneous ic_rden / dc_rden from reset
        rst = 1;
        step();
        rst = 0;
        step();
`ifdef ARB_ROUND_ROBIN_EN
        first_addr = 64'h4000; second_addr = 64'h5000;
`else
        first_addr = 64'h5000; second_addr = 64'h4000;
`endif
        ic_rden = 1; ic_addr = 64'h4000; dc_rden = 1; dc_addr = 64'h5000;
        step();
        check("t3_first_addr", mem_addr, first_addr);
        mem_ready = 1;
        #1;
        check("t3_first_ic_ready", ic_ready, first_addr == 64'h4000);
        check("t3_first_dc_ready", dc_ready, first_addr == 64'h5000);
        step();
        mem_ready = 0;
        if (first_addr == 64'h4000) ic_rden = 0; else dc_rden = 0;
        step();
        check("t3_second_addr", mem_addr, second_addr);
        check("t3_second_rden", mem_rden, 1);
        mem_ready = 1;
        step();
        mem_ready = 0; ic_rden = 0; dc_rden = 0;
        step();

        // Watchdog: mem_ready on the 8th busy cycle leaves timeout_err clear
        ic_rden = 1; ic_addr = 64'h7000;
        for (int i = 0; i < 7; i++) step();
        check("t4_7cyc_pre", timeout_err, 0);
        step();
        mem_ready = 1;
        step();
        mem_ready = 0; ic_rden = 0;
        check("t4_7cyc_err", timeout_err, 0);
        check("t4_7cyc_idle", busy, 0);
        step();
        // Eight busy cycles without mem_ready set the sticky flag
        ic_rden = 1;
        for (int i = 0; i < 9; i++) step();
        check("t4_8cyc_err", timeout_err, 1);
        check("t4_8cyc_busy", busy, 1);
        mem_ready = 1;
        step();
        mem_ready = 0; ic_rden = 0;
        check("t4_sticky", timeout_err, 1);
        check("t4_done", busy, 0);

        // Asynchronous reset in the middle of a write-back
        step();
        dc_wren = 1; dc_addr = 64'h8000; dc_wdata = pat_5;
        step();
        check("t5_wren", mem_wren, 1);
        #2;
        rst = 1;
        #1;
        check("t5_async_wren", mem_wren, 0);
        check("t5_async_busy", busy, 0);
        check("t5_async_err", timeout_err, 0);
        check("t5_async_addr", mem_addr, 0);
        dc_wren = 0;
        step();
        rst = 0;
        dc_rden = 1; dc_addr = 64'h6000;
        step();
        check("t5_regrant_rden", mem_rden, 1);
        check("t5_regrant_addr", mem_addr, 64'h6000);
        mem_ready = 1;
        #1;
        check("t5_regrant_ready", dc_ready, 1);
        step();
        mem_ready = 0; dc_rden = 0;

        // mem_ready in IDLE is ignored
        step();
        mem_ready = 1;
        #1;
        check("t6_ic_ready", ic_ready, 0);
        check("t6_dc_ready", dc_ready, 0);
        step();
        mem_ready = 0;
        check("t6_idle", busy, 0);
        check("t6_no_strobe", mem_rden | mem_wren, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
